// File: rtl/gelato_wb_arbiter.sv
// Round-robin writeback arbiter with multi-beat source locking.
// The winning beat lands in a one-entry registered stage feeding the register file.
module gelato_wb_arbiter #(
    parameter int NUM_SRC       = 3,
    parameter int NUM_THREADS   = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int WARP_ID_WIDTH = 5,
    parameter int REG_ID_WIDTH  = 5,
    parameter int SW            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      rdy,
    input  logic [NUM_SRC-1:0]                        src_valid,
    output logic [NUM_SRC-1:0]                        src_ready,
    input  logic [NUM_SRC-1:0]                        src_last,
    input  logic [NUM_SRC*WARP_ID_WIDTH-1:0]          src_warp_id,
    input  logic [NUM_SRC*REG_ID_WIDTH-1:0]           src_rd,
    input  logic [NUM_SRC*NUM_THREADS-1:0]            src_mask,
    input  logic [NUM_SRC*NUM_THREADS*DATA_WIDTH-1:0] src_data,
    output logic                                      rf_valid,
    input  logic                                      rf_ready,
    output logic [WARP_ID_WIDTH-1:0]                  rf_warp_id,
    output logic [REG_ID_WIDTH-1:0]                   rf_rd,
    output logic [NUM_THREADS-1:0]                    rf_mask,
    output logic [NUM_THREADS*DATA_WIDTH-1:0]         rf_data,
    output logic [SW-1:0]                             rf_src
);

    localparam int LW = NUM_THREADS * DATA_WIDTH;

    logic                     r_rf_valid;
    logic [WARP_ID_WIDTH-1:0] r_rf_warp_id;
    logic [REG_ID_WIDTH-1:0]  r_rf_rd;
    logic [NUM_THREADS-1:0]   r_rf_mask;
    logic [LW-1:0]            r_rf_data;
    logic [SW-1:0]            r_rf_src;
    logic [SW-1:0]            r_last_grant;
    logic                     r_lock_active;
    logic [SW-1:0]            r_lock_src;

    logic                     w_load_en;
    logic                     w_grant_valid;
    logic [SW-1:0]            w_grant;
    logic                     w_xfer;
    int                       w_cand;
    logic [SW-1:0]            w_idx;
    logic                     w_sel_last;
    logic [WARP_ID_WIDTH-1:0] w_sel_warp_id;
    logic [REG_ID_WIDTH-1:0]  w_sel_rd;
    logic [NUM_THREADS-1:0]   w_sel_mask;
    logic [LW-1:0]            w_sel_data;

    assign w_load_en = rdy && (!r_rf_valid || rf_ready);
    assign w_xfer    = w_load_en && w_grant_valid;

    // Descending scan so the nearest index after last_grant is written last and wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_cand        = 0;
        w_idx         = '0;
        if (r_lock_active) begin
            w_grant_valid = src_valid[r_lock_src];
            w_grant       = r_lock_src;
        end else begin
            for (int k = NUM_SRC; k >= 1; k--) begin
                w_cand = (int'(r_last_grant) + k) % NUM_SRC;
                w_idx  = SW'(w_cand);
                if (src_valid[w_idx]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = w_idx;
                end
            end
        end
    end

    always_comb begin
        src_ready     = '0;
        w_sel_last    = 1'b0;
        w_sel_warp_id = '0;
        w_sel_rd      = '0;
        w_sel_mask    = '0;
        w_sel_data    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant == SW'(i)) begin
                src_ready[i]  = w_xfer;
                w_sel_last    = src_last[i];
                w_sel_warp_id = src_warp_id[i*WARP_ID_WIDTH +: WARP_ID_WIDTH];
                w_sel_rd      = src_rd[i*REG_ID_WIDTH +: REG_ID_WIDTH];
                w_sel_mask    = src_mask[i*NUM_THREADS +: NUM_THREADS];
                w_sel_data    = src_data[i*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_valid    <= 1'b0;
            r_rf_warp_id  <= '0;
            r_rf_rd       <= '0;
            r_rf_mask     <= '0;
            r_rf_data     <= '0;
            r_rf_src      <= '0;
            r_last_grant  <= SW'(NUM_SRC - 1);
            r_lock_active <= 1'b0;
            r_lock_src    <= '0;
        end else if (rdy) begin
            if (w_xfer) begin
                r_rf_valid    <= 1'b1;
                r_rf_warp_id  <= w_sel_warp_id;
                r_rf_rd       <= w_sel_rd;
                r_rf_mask     <= w_sel_mask;
                r_rf_data     <= w_sel_data;
                r_rf_src      <= w_grant;
                r_last_grant  <= w_grant;
                r_lock_active <= !w_sel_last;
                if (!w_sel_last) begin
                    r_lock_src <= w_grant;
                end
            end else if (r_rf_valid && rf_ready) begin
                r_rf_valid <= 1'b0;
            end
        end
    end

    assign rf_valid   = r_rf_valid;
    assign rf_warp_id = r_rf_warp_id;
    assign rf_rd      = r_rf_rd;
    assign rf_mask    = r_rf_mask;
    assign rf_data    = r_rf_data;
    assign rf_src     = r_rf_src;

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// Directed bench for gelato_wb_arbiter.
// Expected beats are queued on stimulus and popped by an output monitor.
module tb_gelato_wb_arbiter;

    localparam int NS = 3;
    localparam int NT = 32;
    localparam int DW = 32;
    localparam int WW = 5;
    localparam int RW = 5;
    localparam int SW = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  rdy = 1'b1;
    logic [NS-1:0]         src_valid = '0;
    logic [NS-1:0]         src_ready;
    logic [NS-1:0]         src_last = '1;
    logic [NS*WW-1:0]      src_warp_id;
    logic [NS*RW-1:0]      src_rd;
    logic [NS*NT-1:0]      src_mask;
    logic [NS*NT*DW-1:0]   src_data;
    logic                  rf_valid;
    logic                  rf_ready = 1'b1;
    logic [WW-1:0]         rf_warp_id;
    logic [RW-1:0]         rf_rd;
    logic [NT-1:0]         rf_mask;
    logic [NT*DW-1:0]      rf_data;
    logic [SW-1:0]         rf_src;

    typedef struct {
        logic [SW-1:0]    src;
        logic [WW-1:0]    warp;
        logic [RW-1:0]    rd;
        logic [NT-1:0]    mask;
        logic [NT*DW-1:0] data;
    } beat_t;

    beat_t      q[$];
    logic [4:0] rd_v[NS];
    int         errors = 0;
    int         checks = 0;

    gelato_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_last    (src_last),
        .src_warp_id (src_warp_id),
        .src_rd      (src_rd),
        .src_mask    (src_mask),
        .src_data    (src_data),
        .rf_valid    (rf_valid),
        .rf_ready    (rf_ready),
        .rf_warp_id  (rf_warp_id),
        .rf_rd       (rf_rd),
        .rf_mask     (rf_mask),
        .rf_data     (rf_data),
        .rf_src      (rf_src)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input int s, input logic [4:0] rd);
        beat_t b;
        b.src  = SW'(s);
        b.rd   = rd;
        b.warp = rd ^ 5'(s + 1);
        b.mask = {8'(s + 1), 19'h5A5A5, rd};
        for (int l = 0; l < NT; l++)
            b.data[l*DW +: DW] = {8'(s), 3'b0, rd, 16'(l)};
        return b;
    endfunction

    task automatic drive();
        beat_t b;
        for (int i = 0; i < NS; i++) begin
            b = mk(i, rd_v[i]);
            src_warp_id[i*WW +: WW]      = b.warp;
            src_rd[i*RW +: RW]           = b.rd;
            src_mask[i*NT +: NT]         = b.mask;
            src_data[i*NT*DW +: NT*DW]   = b.data;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [NS-1:0] exp_rdy);
        drive();
        @(negedge clk);
        chk("src_ready", 64'(src_ready), 64'(exp_rdy));
        for (int i = 0; i < NS; i++)
            if (exp_rdy[i]) q.push_back(mk(i, rd_v[i]));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && rdy && rf_valid && rf_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rf_beat: got rd %0h src %0h expected none",
                         rf_rd, rf_src);
            end else begin
                e = q.pop_front();
                chk("rf_src", 64'(rf_src), 64'(e.src));
                chk("rf_rd", 64'(rf_rd), 64'(e.rd));
                chk("rf_warp_id", 64'(rf_warp_id), 64'(e.warp));
                chk("rf_mask", 64'(rf_mask), 64'(e.mask));
                checks++;
                if (rf_data !== e.data) begin
                    errors++;
                    $display("FAIL rf_data: got %0h expected %0h",
                             rf_data, e.data);
                end
            end
        end
    end

    initial begin
        logic [NS-1:0] t1[6];
        t1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < NS; i++) rd_v[i] = '0;
        drive();
        @(negedge clk);
        chk("reset_rf_valid", 64'(rf_valid), 64'd0);
        chk("reset_src_ready", 64'(src_ready), 64'd0);
        chk("reset_rf_rd", 64'(rf_rd), 64'd0);
        chk("reset_rf_src", 64'(rf_src), 64'd0);
        chk("reset_rf_data", 64'(|rf_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // round robin with all sources valid
        src_valid = 3'b111;
        src_last  = 3'b111;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NS; i++) rd_v[i] = 5'(k * 3 + i + 1);
            step(t1[k]);
        end
        src_valid = '0;
        step(3'b000);

        // lone source streams without bubbles
        src_valid = 3'b010;
        for (int k = 0; k < 4; k++) begin
            rd_v[1] = 5'(5 + k);
            step(3'b010);
            if (k > 0) chk("no_bubble", 64'(rf_valid), 64'd1);
        end
        src_valid = '0;
        step(3'b000);

        // source 2 locks for three beats, source 0 waits
        src_valid = 3'b101;
        src_last  = 3'b001;
        rd_v[0] = 5'd10;
        rd_v[2] = 5'd12;
        step(3'b100);
        src_valid = 3'b001;
        step(3'b000);
        src_valid = 3'b101;
        rd_v[2] = 5'd13;
        step(3'b100);
        src_last = 3'b101;
        rd_v[2] = 5'd14;
        step(3'b100);
        step(3'b001);
        src_valid = '0;
        step(3'b000);

        // back-pressure holds the output stage
        src_valid = 3'b111;
        src_last  = 3'b111;
        rd_v[0] = 5'd1;
        rd_v[1] = 5'd9;
        rd_v[2] = 5'd3;
        step(3'b010);
        rf_ready = 1'b0;
        repeat (5) begin
            step(3'b000);
            chk("stall_rf_rd", 64'(rf_rd), 64'd9);
            chk("stall_rf_valid", 64'(rf_valid), 64'd1);
        end
        rf_ready = 1'b1;
        step(3'b100);
        step(3'b001);
        src_valid = '0;
        step(3'b000);

        // global enable low freezes everything
        src_valid = 3'b111;
        rd_v[0] = 5'd20;
        rd_v[1] = 5'd21;
        rd_v[2] = 5'd22;
        step(3'b010);
        rdy = 1'b0;
        repeat (3) begin
            step(3'b000);
            chk("frz_rf_rd", 64'(rf_rd), 64'd21);
            chk("frz_rf_src", 64'(rf_src), 64'd1);
            chk("frz_rf_valid", 64'(rf_valid), 64'd1);
        end
        rdy = 1'b1;
        step(3'b100);
        step(3'b001);
        src_valid = '0;
        step(3'b000);

        // asynchronous reset in the middle of a locked transfer
        src_valid = 3'b010;
        src_last  = 3'b000;
        rd_v[1] = 5'd25;
        step(3'b010);
        chk("pre_rst_valid", 64'(rf_valid), 64'd1);
        src_valid = 3'b111;
        src_last  = 3'b111;
        rd_v[0] = 5'd26;
        rd_v[1] = 5'd27;
        rd_v[2] = 5'd28;
        drive();
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_rst_valid", 64'(rf_valid), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3'b001);
        step(3'b010);
        src_valid = '0;
        step(3'b000);
        step(3'b000);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
